// File: rtl/serial_frame_rx_pkg.sv
// Shared types and line-level constants for the serial frame receiver.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } state_e;

  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b0;
  localparam logic IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, N data bits LSB first, optional even parity, stop bit.
// Status pulses are registered and last exactly one clock regardless of bit_en.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         serial_in,
  input  logic         bit_en,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LastBit = CW'(N - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   buf_q, buf_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           perr_q, perr_d;
  logic           dv_q, dv_d;
  logic           pe_q, pe_d;
  logic           fe_q, fe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    dout_d  = dout_q;
    perr_d  = perr_q;
    dv_d    = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;
    if (bit_en) begin
      unique case (state_q)
        StIdle: begin
          if (serial_in == START_BIT) begin
            state_d = StData;
            cnt_d   = '0;
            perr_d  = 1'b0;
          end
        end
        StData: begin
          buf_d[cnt_q] = serial_in;
          // Counter parks at the last index rather than wrapping.
          if (cnt_q == LastBit) begin
            state_d = PARITY_EN ? StParity : StStop;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        StParity: begin
          perr_d  = serial_in ^ (^buf_q);
          state_d = StStop;
        end
        StStop: begin
          // A bad stop bit is consumed here and never re-read as a start bit.
          state_d = StIdle;
          if (serial_in != STOP_BIT) begin
            fe_d = 1'b1;
          end else if (perr_q) begin
            pe_d = 1'b1;
          end else begin
            dv_d   = 1'b1;
            dout_d = buf_q;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      buf_q   <= '0;
      dout_q  <= '0;
      perr_q  <= 1'b0;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      dout_q  <= dout_d;
      perr_q  <= perr_d;
      dv_q    <= dv_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter: N, 4, data bits per frame (N >= 2).
REQ-002 Parameter: PARITY_EN, 1, 1 = even-parity bit present after data; 0 = no parity bit.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  reset is synchronous and active-high.
REQ-005 Port: serial_in  input  1  bit stream from the upstream shift register's serial_out; one bit per enabled cycle, LSB first.
REQ-006 Port: bit_en  input  1  qualifier: serial_in is sampled only in cycles with bit_en=1.
REQ-007 Port: data_out  output  N  last correctly framed data word.
REQ-008 Port: data_valid  output  1  one-cycle pulse: data_out updated.
REQ-009 Port: parity_err  output  1  one-cycle pulse: frame received with bad parity.
REQ-010 Port: frame_err  output  1  one-cycle pulse: stop bit not 0.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Frame format: line idles at 0; start bit = 1; N data bits LSB first; parity bit if PARITY_EN; stop bit = 0.
REQ-013 FSM states: IDLE, DATA, PARITY, STOP; transitions only in cycles with bit_en=1.
REQ-014 IDLE: sampled serial_in=1 -> DATA with bit counter cleared; sampled 0 -> stay IDLE.
REQ-015 DATA: each sampled bit is written into shift buffer position given by bit counter (bit k -> buffer[k]); after bit N-1 -> PARITY if PARITY_EN, else STOP.
REQ-016 Bit counter width: $clog2(N) bits; no wrap beyond N-1 is permitted.
REQ-017 PARITY: sampled bit compared to XOR of the N buffered bits; mismatch latched internally; -> STOP.
REQ-018 STOP: sampled 0 with no parity mismatch -> data_out <= buffer, data_valid=1 next cycle.
REQ-019 STOP: sampled 0 with parity mismatch -> parity_err=1 next cycle, data_out unchanged, no data_valid.
REQ-020 STOP: sampled 1 -> frame_err=1 next cycle, data_out unchanged, no data_valid/parity_err; that 1 is not taken as a new start bit.
REQ-021 STOP always -> IDLE; back-to-back frames allowed: a start bit may be sampled in the very next enabled cycle.
REQ-022 Latency (bit_en=1 continuously, PARITY_EN=1): start sampled in cycle 0, data in cycles 1..N, parity cycle N+1, stop cycle N+2, status pulse in cycle N+3.
REQ-023 bit_en=0: FSM, counter, buffer hold; status pulses last exactly one clk cycle regardless of bit_en.
REQ-024 At most one of data_valid, parity_err, frame_err high in any cycle.

Reset
REQ-025 reset=1 at a rising edge: state=IDLE, counter=0, buffer=0, data_out=0, data_valid=0, parity_err=0, frame_err=0, busy=0.
REQ-026 reset overrides bit_en and any in-progress frame; partial frame is discarded with no status pulse.

Structure
REQ-027 Shared package holds the state enumeration (IDLE, DATA, PARITY, STOP), START_BIT=1, STOP_BIT=0 and IDLE_LEVEL=0 constants.
REQ-028 Single module; no sub-module: FSM, counter, buffer and parity are one unit.

Verification (N=4, PARITY_EN=1, bit_en=1 unless stated)
REQ-029 Bits 1,1,0,1,1,1,0 (start,d0..d3,parity,stop) -> data_out=4'hD, data_valid pulse in cycle 7, no errors.
REQ-030 Bits 1,1,0,1,1,0,0 -> parity_err pulse in cycle 7, data_out keeps prior value, no data_valid.
REQ-031 Bits 1,0,1,0,0,0,1 -> frame_err pulse in cycle 7; next cycle serial_in=0 -> stays IDLE, busy=0.
REQ-032 Two frames 4'h3 then 4'hA back to back (14 consecutive bits) -> data_valid in cycles 7 and 14, data_out 4'h3 then 4'hA.
REQ-033 Frame 4'h5 with bit_en low every other cycle -> data_valid pulse width 1 clk, data_out=4'h5.
REQ-034 reset=1 for one cycle after d2 of a frame -> all outputs 0, busy=0, no status pulse; following frame 4'h9 received correctly.
